multicycle_control: RTL

- Main control FSM for the multicycle MIPS datapath.
- Produces the 3-bit ALU operation class consumed by the ALU-control decoder, and receives that decoder's break flag back.
- Sequences fetch/decode/execute/memory/writeback.
- Stretches memory states for a fixed-latency memory.
- Halts the core on BREAK.

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the multicycle FSM and the datapath
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       brk_in;
   logic       pc_write;
   logic       pc_write_cond;
   logic       pc_write_cond_ne;
   logic       iord;
   logic       mem_wr;
   logic       ir_write;
   logic       mdr_write;
   logic       aluout_write;
   logic       reg_dst;
   logic       reg_write;
   logic [1:0] mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal_op;
   logic       halted;

   modport master (
      input  opcode, brk_in,
      output pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_wr, ir_write,
             mdr_write, aluout_write, reg_dst, reg_write, mem_to_reg, alu_src_a,
             alu_src_b, alu_op, pc_source, illegal_op, halted
   );

   modport slave (
      output opcode, brk_in,
      input  pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_wr, ir_write,
             mdr_write, aluout_write, reg_dst, reg_write, mem_to_reg, alu_src_a,
             alu_src_b, alu_op, pc_source, illegal_op, halted
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle MIPS datapath
// Memory states last MEM_WAIT+1 cycles; BREAK parks the core in HALT until reset.
module multicycle_control #(
   parameter int MEM_WAIT = 2
) (
   input logic               clk,
   input logic               reset,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR, S_MEM_READ, S_MEM_WB,
      S_MEM_WRITE, S_BRANCH, S_JUMP, S_EXEC_I, S_WB_I, S_LUI, S_HALT
   } state_t;

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

   state_t     state, state_next;
   logic [2:0] wait_cnt;
   logic       last;
   logic       in_mem;

   assign last   = (wait_cnt == WAIT_LAST);
   assign in_mem = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);

   // No memory state re-enters itself, so "same state next cycle" means "still waiting".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_RST;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= (in_mem && state_next == state) ? wait_cnt + 3'd1 : 3'd0;
      end
   end

   always_comb begin
      state_next           = state;
      bus.pc_write         = 1'b0;
      bus.pc_write_cond    = 1'b0;
      bus.pc_write_cond_ne = 1'b0;
      bus.iord             = 1'b0;
      bus.mem_wr           = 1'b0;
      bus.ir_write         = 1'b0;
      bus.mdr_write        = 1'b0;
      bus.aluout_write     = 1'b0;
      bus.reg_dst          = 1'b0;
      bus.reg_write        = 1'b0;
      bus.mem_to_reg       = 2'b00;
      bus.alu_src_a        = 1'b0;
      bus.alu_src_b        = 2'b00;
      bus.alu_op           = 3'b000;
      bus.pc_source        = 2'b00;
      bus.illegal_op       = 1'b0;
      bus.halted           = 1'b0;

      case (state)
         S_RST: state_next = S_FETCH;
         S_FETCH: begin
            bus.alu_src_b = 2'b01;
            if (last) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_next   = S_DECODE;
            end
         end
         S_DECODE: begin
            bus.alu_src_b    = 2'b11;
            bus.aluout_write = 1'b1;
            case (bus.opcode)
               6'h00:        state_next = bus.brk_in ? S_HALT : S_EXEC_R;
               6'h23, 6'h2b: state_next = S_ADDR;
               6'h04, 6'h05: state_next = S_BRANCH;
               6'h02:        state_next = S_JUMP;
               6'h08, 6'h09: state_next = S_EXEC_I;
               6'h0f:        state_next = S_LUI;
               default: begin
                  bus.illegal_op = 1'b1;
                  state_next     = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            bus.alu_src_a    = 1'b1;
            bus.alu_op       = 3'b010;
            bus.aluout_write = 1'b1;
            state_next       = S_WB_R;
         end
         S_WB_R: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = 1'b1;
            state_next    = S_FETCH;
         end
         S_ADDR: begin
            bus.alu_src_a    = 1'b1;
            bus.alu_src_b    = 2'b10;
            bus.aluout_write = 1'b1;
            state_next       = (bus.opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            bus.iord = 1'b1;
            if (last) begin
               bus.mdr_write = 1'b1;
               state_next    = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            bus.mem_to_reg = 2'b01;
            bus.reg_write  = 1'b1;
            state_next     = S_FETCH;
         end
         S_MEM_WRITE: begin
            bus.iord   = 1'b1;
            bus.mem_wr = 1'b1;
            if (last) state_next = S_FETCH;
         end
         S_BRANCH: begin
            bus.alu_src_a        = 1'b1;
            bus.alu_op           = 3'b001;
            bus.pc_source        = 2'b01;
            bus.pc_write_cond    = (bus.opcode == 6'h04);
            bus.pc_write_cond_ne = (bus.opcode == 6'h05);
            state_next           = S_FETCH;
         end
         S_JUMP: begin
            bus.pc_source = 2'b10;
            bus.pc_write  = 1'b1;
            state_next    = S_FETCH;
         end
         S_EXEC_I: begin
            bus.alu_src_a    = 1'b1;
            bus.alu_src_b    = 2'b10;
            bus.aluout_write = 1'b1;
            state_next       = S_WB_I;
         end
         S_WB_I: begin
            bus.reg_write = 1'b1;
            state_next    = S_FETCH;
         end
         S_LUI: begin
            bus.mem_to_reg = 2'b10;
            bus.reg_write  = 1'b1;
            state_next     = S_FETCH;
         end
         S_HALT: bus.halted = 1'b1;
         default: state_next = S_RST;
      endcase
   end
endmodule
